// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Multi-cycle multiply/divide sequencer for the five-stage pipeline. When a
// mul/div ALU op sits in execute it stalls the front of the pipe, pulses the
// start strobe of the shared mult/div unit, waits for the unit's ready level,
// then issues exactly one register-file writeback: the result to rd, or an
// exception code to the status register.
//
// Optional feature: define MD_TIMEOUT_EN to compile in a wait counter that
// aborts WAIT with exception code 3 after TIMEOUT cycles without md_rdy.
// In the default build the counter and the timeout path are absent and WAIT
// persists until md_rdy or flush.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   op_valid   in   R-type instruction valid in execute
//   aluop      in   [4:0] ALU opcode of the execute-stage instruction
//   rd_in      in   [4:0] destination register of that instruction
//   flush      in   squash the execute-stage instruction
//   md_rdy     in   mult/div result ready (level)
//   md_exc     in   mult/div exception, qualified by md_rdy
//   ctrl_mult  out  one-cycle multiplier start pulse
//   ctrl_div   out  one-cycle divider start pulse
//   stall      out  freeze PC, F/D and D/X latches
//   wb_en      out  register-file write enable
//   wb_sel     out  0 = mult/div result, 1 = zero-extended exc_code
//   wb_rd      out  [4:0] writeback register number
//   exc_code   out  [2:0] 0 none, 1 mul overflow, 2 div exception, 3 timeout
//   busy       out  sequencer is not idle
//
// Handshake with the mult/div unit: the start strobe (ctrl_mult/ctrl_div) is
// a single-cycle pulse in START; the unit answers by holding md_rdy high
// (with md_exc valid alongside it). md_rdy is only looked at in WAIT, so a
// stale or late ready level in any other state has no effect.
// ---------------------------------------------------------------------------
module md_sequencer #(
`ifdef MD_TIMEOUT_EN
   parameter int         TIMEOUT    = 40,
   parameter int         CNT_W      = 6,
`endif
   parameter logic [4:0] OP_MUL     = 5'b00110,
   parameter logic [4:0] OP_DIV     = 5'b00111,
   parameter logic [4:0] STATUS_REG = 5'd30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       op_valid,
   input  logic [4:0] aluop,
   input  logic [4:0] rd_in,
   input  logic       flush,
   input  logic       md_rdy,
   input  logic       md_exc,
   output logic       ctrl_mult,
   output logic       ctrl_div,
   output logic       stall,
   output logic       wb_en,
   output logic       wb_sel,
   output logic [4:0] wb_rd,
   output logic [2:0] exc_code,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [2:0] EXC_NONE = 3'd0;
   localparam logic [2:0] EXC_MUL  = 3'd1;
   localparam logic [2:0] EXC_DIV  = 3'd2;
`ifdef MD_TIMEOUT_EN
   localparam logic [2:0] EXC_TMO  = 3'd3;
`endif

   state_e     state_q, state_d;
   logic       is_div_q, is_div_d;
   logic [4:0] rd_q, rd_d;
   logic [2:0] exc_q, exc_d;
`ifdef MD_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   logic is_mul_op, is_div_op, launch;

   assign is_mul_op = (aluop == OP_MUL);
   assign is_div_op = (aluop == OP_DIV);
   assign launch    = op_valid & ~flush & (is_mul_op | is_div_op);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         is_div_q <= 1'b0;
         rd_q     <= '0;
         exc_q    <= EXC_NONE;
      end else begin
         state_q  <= state_d;
         is_div_q <= is_div_d;
         rd_q     <= rd_d;
         exc_q    <= exc_d;
      end
   end

`ifdef MD_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      is_div_d = is_div_q;
      rd_d     = rd_q;
      exc_d    = exc_q;
`ifdef MD_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d  = S_START;
               is_div_d = is_div_op;
               rd_d     = rd_in;
               exc_d    = EXC_NONE;
            end
         end

         S_START: begin
`ifdef MD_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = flush ? S_IDLE : S_WAIT;
         end

         S_WAIT: begin
            // flush wins over a same-cycle ready: the op is squashed
            if (flush) begin
               state_d = S_IDLE;
            end else if (md_rdy) begin
               state_d = S_DONE;
               if (md_exc) begin
                  exc_d = is_div_q ? EXC_DIV : EXC_MUL;
               end else begin
                  exc_d = EXC_NONE;
               end
`ifdef MD_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // this is the TIMEOUT-th WAIT cycle without a ready
               state_d = S_DONE;
               exc_d   = EXC_TMO;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end

         S_DONE: begin
            // instruction still visible in execute here; never relaunch it
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: everything but stall is decoded from registered state only
   // ------------------------------------------------------------------------
   assign busy      = (state_q != S_IDLE);
   assign ctrl_mult = (state_q == S_START) & ~is_div_q;
   assign ctrl_div  = (state_q == S_START) &  is_div_q;
   assign wb_en     = (state_q == S_DONE);
   assign wb_sel    = (state_q == S_DONE) & (exc_q != EXC_NONE);
   assign wb_rd     = (state_q != S_DONE)    ? 5'd0 :
                      (exc_q != EXC_NONE)    ? STATUS_REG : rd_q;
   assign exc_code  = exc_q;

   // The launch term is gated by reset so stall stays low while reset is
   // held even if a mul/div op is presented.
   assign stall = reset & (((state_q == S_IDLE) & launch) |
                           (state_q == S_START) |
                           (state_q == S_WAIT));

endmodule
